// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin sharing of a single UART transmitter between N byte producers.
// A granted byte is latched, issued as a one-cycle tx_req, and no new grant is
// made until the transmitter has gone busy and returned to idle.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// S_IDLE    | waiting for tx_ready=1 and a request; grant and latch on one edge
// S_ISSUE   | ack pulse visible; next edge raises tx_req
// S_WAIT_LO | tx_req pulse visible, then waiting for tx_ready=0 (byte taken)
// S_WAIT_HI | transmitter sending; waiting for tx_ready=1 before re-granting
module uart_tx_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N*8-1:0]   data,
    output logic [N-1:0]     ack,
    output logic [7:0]       tx_data,
    output logic             tx_req,
    input  logic             tx_ready,
    output logic             busy,
    output logic [IDW-1:0]   grant_id
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_LO = 2'd2,
        S_WAIT_HI = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [IDW-1:0] r_last;
    logic [IDW-1:0] w_last_nxt;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] w_grant_id_nxt;
    logic [N-1:0]   r_ack;
    logic [N-1:0]   w_ack_nxt;
    logic [7:0]     r_tx_data;
    logic [7:0]     w_tx_data_nxt;
    logic           r_tx_req;
    logic           w_tx_req_nxt;
    logic           r_busy;

    logic [IDW-1:0] w_idx;
    logic [IDW-1:0] w_win;
    logic           w_found;

    // Round-robin search: first requesting index after r_last, wrapping N-1 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = r_last;
        for (int k = 0; k < N; k++) begin
            w_idx = (w_idx == IDW'(N - 1)) ? '0 : w_idx + 1'b1;
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Next-state and next-output decode; registers hold unless a state acts.
    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_grant_id_nxt = r_grant_id;
        w_tx_data_nxt  = r_tx_data;
        w_ack_nxt      = '0;
        w_tx_req_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_ready && w_found) begin
                    w_tx_data_nxt        = data[{w_win, 3'b000} +: 8];
                    w_ack_nxt[w_win]     = 1'b1;
                    w_grant_id_nxt       = w_win;
                    w_last_nxt           = w_win;
                    w_state_nxt          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_tx_req_nxt = 1'b1;
                w_state_nxt  = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!tx_ready) begin
                    w_state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (tx_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset drops any latched byte but cannot
    // stop a transmitter that is already sending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last     <= IDW'(N - 1);
            r_grant_id <= '0;
            r_tx_data  <= 8'h00;
            r_ack      <= '0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_ack      <= w_ack_nxt;
            r_tx_req   <= w_tx_req_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    assign ack      = r_ack;
    assign tx_data  = r_tx_data;
    assign tx_req   = r_tx_req;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;

endmodule
